// File: rtl/lenet_image_feeder_if.sv
// Bundles the control, pixel-memory and pixel-stream signals of lenet_image_feeder.
//   master : feeder side. It drives rom_addr/rom_en, map_in/en, busy/done and frame_idx.
//   slave  : environment side. It drives start/abort/n_frames/layer1_finish and rom_data.
interface lenet_image_feeder_if #(
  parameter int unsigned ADDR_W = 16
);
  logic                     start;
  logic                     abort;
  logic        [7:0]        n_frames;
  logic                     layer1_finish;
  logic        [ADDR_W-1:0] rom_addr;
  logic                     rom_en;
  logic signed [15:0]       rom_data;
  logic signed [15:0]       map_in;
  logic                     en;
  logic                     busy;
  logic                     done;
  logic        [7:0]        frame_idx;

  modport master (
    input  start, abort, n_frames, layer1_finish, rom_data,
    output rom_addr, rom_en, map_in, en, busy, done, frame_idx
  );

  modport slave (
    output start, abort, n_frames, layer1_finish, rom_data,
    input  rom_addr, rom_en, map_in, en, busy, done, frame_idx
  );
endinterface

// File: rtl/lenet_image_feeder.sv
// Frame streamer for the LeNet pixel input. It reads n_frames images in raster order from a
// synchronous pixel memory. Each image is sent as a gap-free IMG_W x IMG_H burst on map_in/en.
// After each burst the feeder waits for layer1_finish before it starts the next one.
// Ports:
//   clk   : single clock, rising edge
//   reset : asynchronous, active-high
//   bus   : lenet_image_feeder_if.master, which carries the control, memory and stream signals
// Build option FEEDER_ZERO_PAD_EN: the memory holds (IMG_W-2*PAD)x(IMG_H-2*PAD) images, and the
// feeder inserts a PAD-wide zero border around each one.
module lenet_image_feeder #(
  parameter int unsigned IMG_W  = 32,
  parameter int unsigned IMG_H  = 32,
  parameter int unsigned PAD    = 2,
  parameter int unsigned ADDR_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  lenet_image_feeder_if.master bus
);

  localparam int unsigned CntW = 16;
  localparam logic [CntW-1:0] LastCol = CntW'(IMG_W - 1);
  localparam logic [CntW-1:0] LastRow = CntW'(IMG_H - 1);
`ifdef FEEDER_ZERO_PAD_EN
  localparam logic [ADDR_W-1:0] SrcWords = ADDR_W'((IMG_W - 2 * PAD) * (IMG_H - 2 * PAD));
  localparam logic [CntW-1:0]   PadLo    = CntW'(PAD);
  localparam logic [CntW-1:0]   RowHi    = CntW'(IMG_H - PAD);
  localparam logic [CntW-1:0]   ColHi    = CntW'(IMG_W - PAD);
`else
  localparam logic [ADDR_W-1:0] SrcWords = ADDR_W'(IMG_W * IMG_H);
`endif

  typedef enum logic [1:0] {StIdle, StStream, StWaitL1, StDone} state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    row_q, row_d, col_q, col_d;
  logic [ADDR_W-1:0]  off_q, off_d, base_q, base_d;
  logic [7:0]         fidx_q, fidx_d, nfr_q, nfr_d;
  logic               busy_q, busy_d, done_q, done_d;
  // Stage 0: memory request plus its tag. Stage 1: data returning. Stage 2: registered output.
  logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
  logic               rom_en_q, rom_en_d;
  logic               v0_q, v0_d, pad0_q, pad0_d, v1_q, v1_d, pad1_q, pad1_d;
  logic signed [15:0] map_in_q, map_in_d;
  logic               en_q, en_d;
  logic               is_pad;

`ifdef FEEDER_ZERO_PAD_EN
  assign is_pad = (row_q < PadLo) || (row_q >= RowHi) || (col_q < PadLo) || (col_q >= ColHi);
`else
  assign is_pad = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    off_d      = off_q;
    base_d     = base_q;
    fidx_d     = fidx_q;
    nfr_d      = nfr_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    rom_addr_d = rom_addr_q;
    rom_en_d   = 1'b0;
    v0_d       = 1'b0;
    pad0_d     = 1'b0;
    v1_d       = v0_q;
    pad1_d     = pad0_q;
    en_d       = v1_q;
    map_in_d   = v1_q ? (pad1_q ? 16'sd0 : bus.rom_data) : map_in_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StStream;
          row_d   = '0;
          col_d   = '0;
          off_d   = '0;
          base_d  = '0;
          fidx_d  = '0;
          nfr_d   = (bus.n_frames == 8'd0) ? 8'd1 : bus.n_frames;
          busy_d  = 1'b1;
        end
      end
      StStream: begin
        v0_d   = 1'b1;
        pad0_d = is_pad;
        if (!is_pad) begin
          rom_en_d   = 1'b1;
          rom_addr_d = base_q + off_q;
          off_d      = off_q + 1'b1;
        end
        if (col_q == LastCol) begin
          col_d = '0;
          row_d = row_q + 1'b1;
          if (row_q == LastRow) state_d = StWaitL1;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      StWaitL1: begin
        // The last pixels may still be in stages 0-2. They drain on their own.
        if (bus.layer1_finish) begin
          if (({1'b0, fidx_q} + 9'd1) < {1'b0, nfr_q}) begin
            state_d = StStream;
            fidx_d  = fidx_q + 8'd1;
            base_d  = base_q + SrcWords;
            row_d   = '0;
            col_d   = '0;
            off_d   = '0;
          end else begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: state_d = StIdle;
    endcase

    // Abort drops every in-flight tag. No more pixels are sent and done is not pulsed.
    if (bus.abort && (state_q != StIdle)) begin
      state_d  = StIdle;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      rom_en_d = 1'b0;
      v0_d     = 1'b0;
      pad0_d   = 1'b0;
      v1_d     = 1'b0;
      pad1_d   = 1'b0;
      en_d     = 1'b0;
      map_in_d = map_in_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      row_q      <= '0;
      col_q      <= '0;
      off_q      <= '0;
      base_q     <= '0;
      fidx_q     <= '0;
      nfr_q      <= 8'd1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rom_addr_q <= '0;
      rom_en_q   <= 1'b0;
      v0_q       <= 1'b0;
      pad0_q     <= 1'b0;
      v1_q       <= 1'b0;
      pad1_q     <= 1'b0;
      map_in_q   <= '0;
      en_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      off_q      <= off_d;
      base_q     <= base_d;
      fidx_q     <= fidx_d;
      nfr_q      <= nfr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rom_addr_q <= rom_addr_d;
      rom_en_q   <= rom_en_d;
      v0_q       <= v0_d;
      pad0_q     <= pad0_d;
      v1_q       <= v1_d;
      pad1_q     <= pad1_d;
      map_in_q   <= map_in_d;
      en_q       <= en_d;
    end
  end

  assign bus.rom_addr  = rom_addr_q;
  assign bus.rom_en    = rom_en_q;
  assign bus.map_in    = map_in_q;
  assign bus.en        = en_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.frame_idx = fidx_q;

endmodule

// File: tb/tb_lenet_image_feeder.sv
module tb_lenet_image_feeder;
  localparam int W    = 32;
  localparam int H    = 32;
  localparam int PAD  = 2;
  localparam int NPIX = W * H;
`ifdef FEEDER_ZERO_PAD_EN
  localparam int SRC     = (W - 2 * PAD) * (H - 2 * PAD);
  localparam int ROM_LAG = PAD * W + PAD;
`else
  localparam int SRC     = NPIX;
  localparam int ROM_LAG = 0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  logic [15:0] salt;

  lenet_image_feeder_if #(.ADDR_W(16)) bus ();

  lenet_image_feeder #(.IMG_W(W), .IMG_H(H), .PAD(PAD), .ADDR_W(16)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] mem_val(input logic [15:0] a);
    return a ^ salt;
  endfunction

  // Synchronous pixel memory with one cycle of read latency.
  always @(posedge clk) if (bus.rom_en) bus.rom_data <= mem_val(bus.rom_addr);

  // Reference pixel for frame f at (r, c), derived from the image layout.
  function automatic logic [15:0] exp_pix(input int f, input int r, input int c);
    int a;
`ifdef FEEDER_ZERO_PAD_EN
    if (r < PAD || r >= H - PAD || c < PAD || c >= W - PAD) return 16'd0;
    a = f * SRC + (r - PAD) * (W - 2 * PAD) + (c - PAD);
`else
    a = f * SRC + r * W + c;
`endif
    return mem_val(16'(a));
  endfunction

  logic [15:0] en_pix[$];
  int          en_cyc[$];
  int          rom_cyc[$];
  logic [15:0] rom_adr[$];
  int          done_cnt;
  int          done_cyc;
  logic        busy_at_done;

  always @(negedge clk) begin
    if (bus.en) begin
      en_pix.push_back(bus.map_in);
      en_cyc.push_back(cyc);
    end
    if (bus.rom_en) begin
      rom_cyc.push_back(cyc);
      rom_adr.push_back(bus.rom_addr);
    end
    if (bus.done) begin
      done_cnt++;
      done_cyc = cyc;
      busy_at_done = bus.busy;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    en_pix.delete();
    en_cyc.delete();
    rom_cyc.delete();
    rom_adr.delete();
    done_cnt = 0;
    done_cyc = -1;
    busy_at_done = 1'bx;
  endtask

  task automatic wait_pix(input int n);
    int k = 0;
    while (en_pix.size() < n && k < 4000) begin
      @(negedge clk);
      k++;
    end
    chk("wait_pix_bound", 32'(en_pix.size() >= n), 1);
  endtask

  task automatic start_pulse(input int nf_in, output int t0);
    @(negedge clk);
    bus.n_frames = 8'(nf_in);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
    bus.start = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_rom_addr"}, 32'(bus.rom_addr), 0);
    chk({tag, "_rom_en"}, 32'(bus.rom_en), 0);
    chk({tag, "_map_in"}, 32'(bus.map_in), 0);
    chk({tag, "_en"}, 32'(bus.en), 0);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_done"}, 32'(bus.done), 0);
    chk({tag, "_frame_idx"}, 32'(bus.frame_idx), 0);
  endtask

  task automatic run_job(input int nf_in, input bit noise);
    int nf, t0, first, nbad;
    int tf[$];
    nf = (nf_in == 0) ? 1 : nf_in;
    clear_mon();
    start_pulse(nf_in, t0);
    chk("busy_after_start", 32'(bus.busy), 1);
    for (int f = 0; f < nf; f++) begin
      if (noise && f == 0) begin
        // finish and start arrive mid-stream, and n_frames changes. All of these must be ignored.
        wait_pix(300);
        @(negedge clk);
        bus.layer1_finish = 1'b1;
        bus.start = 1'b1;
        bus.n_frames = 8'd7;
        @(negedge clk);
        bus.layer1_finish = 1'b0;
        bus.start = 1'b0;
      end
      wait_pix((f + 1) * NPIX);
      repeat (3) @(negedge clk);
      chk("wait_l1_en_idle", 32'(bus.en), 0);
      chk("wait_l1_rom_idle", 32'(bus.rom_en), 0);
      chk("wait_l1_frame_idx", 32'(bus.frame_idx), 32'(f));
      chk("wait_l1_busy", 32'(bus.busy), 1);
      chk("wait_l1_no_done", 32'(done_cnt), 0);
      chk("wait_l1_rom_count", 32'(rom_cyc.size()), 32'((f + 1) * SRC));
      bus.layer1_finish = 1'b1;
      @(posedge clk);
      #1;
      tf.push_back(cyc);
      bus.layer1_finish = 1'b0;
    end
    repeat (4) @(negedge clk);
    chk("pix_total", 32'(en_pix.size()), 32'(nf * NPIX));
    chk("rom_total", 32'(rom_cyc.size()), 32'(nf * SRC));
    chk("done_count", 32'(done_cnt), 1);
    chk("done_cycle", 32'(done_cyc), 32'(tf[nf-1] + 1));
    chk("busy_at_done", 32'(busy_at_done), 0);
    chk("busy_end", 32'(bus.busy), 0);
    for (int f = 0; f < nf; f++) begin
      first = (f == 0) ? t0 : tf[f-1];
      if (en_pix.size() >= (f + 1) * NPIX) begin
        chk("first_en_cycle", 32'(en_cyc[f*NPIX]), 32'(first + 3));
        chk("en_contiguous", 32'(en_cyc[f*NPIX+NPIX-1] - en_cyc[f*NPIX]), 32'(NPIX - 1));
        nbad = 0;
        for (int r = 0; r < H; r++)
          for (int c = 0; c < W; c++)
            if (en_pix[f*NPIX+r*W+c] !== exp_pix(f, r, c)) nbad++;
        chk("pix_data", 32'(nbad), 0);
      end
      if (rom_cyc.size() >= (f + 1) * SRC) begin
        chk("first_rom_cycle", 32'(rom_cyc[f*SRC]), 32'(first + 1 + ROM_LAG));
        chk("first_rom_addr", 32'(rom_adr[f*SRC]), 32'(16'(f * SRC)));
      end
    end
  endtask

  initial begin
    int t0, nbad;
    salt = 16'd0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.n_frames = 8'd1;
    bus.layer1_finish = 1'b0;
    bus.rom_data = 16'sd0;
    reset = 1'b1;
    clear_mon();
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Memory returns its own address, single frame.
    salt = 16'd0;
    run_job(1, 1'b0);

    // Three frames with random data, plus ignored mid-stream finish/start.
    salt = 16'($urandom);
    run_job(3, 1'b1);

    // Random frame count, and n_frames = 0 behaving as 1.
    salt = 16'($urandom);
    run_job(int'($urandom_range(2, 3)), 1'b0);
    salt = 16'($urandom);
    run_job(0, 1'b0);

    // Abort after pixel 500 has been seen.
    salt = 16'($urandom);
    clear_mon();
    start_pulse(2, t0);
    wait_pix(501);
    @(negedge clk);
    bus.abort = 1'b1;
    @(posedge clk);
    #1;
    bus.abort = 1'b0;
    chk("abort_rom_en", 32'(bus.rom_en), 0);
    chk("abort_en", 32'(bus.en), 0);
    chk("abort_busy", 32'(bus.busy), 0);
    repeat (10) @(negedge clk);
    chk("abort_pix_bound", 32'(en_pix.size() <= 503), 1);
    chk("abort_no_done", 32'(done_cnt), 0);
    nbad = 0;
    for (int i = 0; i < en_pix.size(); i++)
      if (en_pix[i] !== exp_pix(0, i / W, i % W)) nbad++;
    chk("abort_pix_data", 32'(nbad), 0);
    salt = 16'($urandom);
    run_job(1, 1'b0);

    // Asynchronous reset between clock edges in the middle of a frame.
    clear_mon();
    start_pulse(1, t0);
    wait_pix(200);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check_outputs_zero("async_reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    clear_mon();
    repeat (20) @(negedge clk);
    chk("post_reset_no_en", 32'(en_pix.size()), 0);
    chk("post_reset_no_rom", 32'(rom_cyc.size()), 0);
    chk("post_reset_busy", 32'(bus.busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/lenet_image_feeder.md
# lenet_image_feeder

Frame streamer that drives the LeNet pixel input (`map_in`/`en`) from a synchronous pixel memory. It reads one or more images in raster order and emits each as a contiguous 32x32 burst of signed 16-bit pixels. Between frames it waits for `layer1_finish` from the network before starting the next burst. It sits in front of the LeNet top level, on the transmit side of the input stream LeNet consumes.

## Interface
- `IMG_W`, 32, output frame width in pixels
- `IMG_H`, 32, output frame height in pixels
- `PAD`, 2, zero-border width per side (used only with `FEEDER_ZERO_PAD_EN`)
- `ADDR_W`, 16, pixel memory address width
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high; all state and outputs clear immediately.
- `start` in 1: one-cycle request; sampled only in IDLE.
- `abort` in 1: synchronous; returns to IDLE next cycle.
- `n_frames` in 8: frames to send, latched on `start`; 0 is treated as 1.
- `layer1_finish` in 1: network layer-1 completion pulse.
- `rom_addr` out ADDR_W: pixel memory read address.
- `rom_en` out 1: pixel memory read enable.
- `rom_data` in 16 signed: memory read data, valid 1 cycle after `rom_en`.
- `map_in` out 16 signed: pixel to LeNet.
- `en` out 1: `map_in` valid.
- `busy` out 1: high from the cycle after an accepted `start` until `done`.
- `done` out 1: one-cycle pulse after the final frame completes.
- `frame_idx` out 8: index of the frame being sent.

## Operation
- States:
  - IDLE: `start` -> STREAM; latch `n_frames`; `frame_idx`=0.
  - STREAM: walks row/col counters (col fastest) over IMG_W*IMG_H positions, one per cycle, no gaps. After the last position -> WAIT_L1.
  - WAIT_L1: `layer1_finish` -> STREAM if `frame_idx+1 < n_frames` (increment `frame_idx`, clear counters), else DONE.
  - DONE: `done`=1 for one cycle -> IDLE; `busy` drops in the same cycle `done` rises.
- Source word per frame: SRC = IMG_W*IMG_H (no pad) or (IMG_W-2*PAD)*(IMG_H-2*PAD) (pad).
- Frame base = `frame_idx`*SRC, computed with an accumulator, not a multiplier. `rom_addr` = base + source offset, truncated to ADDR_W (wraps modulo 2^ADDR_W).
- Pipeline: stage 0 issues `rom_addr`/`rom_en` plus a valid tag; stage 1 receives `rom_data`; stage 2 registers `map_in`/`en`.
- `layer1_finish` outside WAIT_L1 is ignored.
- `start` outside IDLE is ignored.
- `abort` in any non-IDLE state:
  - `rom_en`, `en`, `busy` go low the next cycle.
  - In-flight pipeline tags are flushed and no further `en` is produced.
  - `done` is not pulsed.
- `abort` and `start` together in IDLE: `start` wins.

## Timing
- Reset values: `rom_addr`=0, `rom_en`=0, `map_in`=0, `en`=0, `busy`=0, `done`=0, `frame_idx`=0.
- `start` at edge T: STREAM entered at T+1; first `rom_en` during cycle T+1; first `en` during cycle T+3.
- Latency address->`map_in` is 2 cycles. Per frame, `en` is high for exactly IMG_W*IMG_H consecutive cycles.
- `map_in` holds its last value when `en`=0.
- `layer1_finish` at edge F in WAIT_L1: next frame's first `rom_en` in cycle F+1; `done` in cycle F+1 for the last frame.
- WAIT_L1 is entered while the last 2 pixels are still in the pipeline. A `layer1_finish` in those cycles is honoured; the pipeline drains normally.

## Configuration
- `FEEDER_ZERO_PAD_EN` defined:
  - Memory holds (IMG_W-2*PAD)x(IMG_H-2*PAD) images (28x28 by default).
  - Positions with row or col < PAD, or >= IMG-PAD, are border: `rom_en`=0 and the tag marks a pad, so `map_in`=0 with `en`=1.
  - Source offset advances only on interior positions.
- Undefined: memory holds full IMG_W x IMG_H images; every position reads memory; pad logic absent.

## Test plan
- No pad, `n_frames`=1, `rom_data`=address: `start` -> `en` high 1024 consecutive cycles from T+3, `map_in` 0..1023. `layer1_finish` -> `done` pulse next cycle, `busy` low.
- Pad build, memory[a]=a+1: row 0 and cols 0,1,30,31 give `map_in`=0. Pixel (2,2)=1, pixel (2,29)=28, last interior (29,29)=784. `rom_en` asserted exactly 784 cycles.
- `n_frames`=3: second burst starts the cycle after the first `layer1_finish`. Second frame's first `rom_addr`=1024 (784 with pad), `frame_idx`=1. `done` only after the third `layer1_finish`.
- `layer1_finish` pulsed mid-STREAM and `start` pulsed while busy: both ignored; the frame still carries 1024 pixels.
- `abort` at pixel 500: `en` at most 2 more pixels then low; no `done`; IDLE. A new `start` restarts at `rom_addr`=0.
- Async `reset` asserted mid-frame between edges: all outputs 0 immediately. After deassert, IDLE with no `en`.
